// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key-schedule controller with round-key bank and read port
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [127:0] key,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic         rk_err,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         key_ready
);

  localparam logic [3:0] NR_L = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] next_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rounds_done_q, rounds_done_d;
  logic [3:0]     round_cnt_q, round_cnt_d;
  logic           i_ready_q, i_ready_d;
  logic           busy_q, busy_d;
  logic           key_ready_q, key_ready_d;
  logic           rk_valid_q, rk_valid_d;
  logic           rk_err_q, rk_err_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [127:0]   last_q, last_d;

  logic [127:0]   bank_q [0:NR];
  logic           bank_we;
  logic [3:0]     bank_waddr;
  logic [127:0]   bank_wdata;

  logic           load;
  logic           rd_ok;
  logic [3:0]     rd_sel;
  logic [127:0]   next_key;

  // The previous round key is kept in last_q so expansion never needs a bank read.
  assign next_key = next_round(last_q, rcon(round_cnt_q));
  assign load     = i_valid && i_ready_q;

  always_comb begin
    state_d       = state_q;
    rounds_done_d = rounds_done_q;
    round_cnt_d   = round_cnt_q;
    i_ready_d     = i_ready_q;
    busy_d        = busy_q;
    key_ready_d   = key_ready_q;
    last_d        = last_q;
    bank_we       = 1'b0;
    bank_waddr    = round_cnt_q;
    bank_wdata    = next_key;

    if (load) begin
      state_d       = S_EXPAND;
      bank_we       = 1'b1;
      bank_waddr    = 4'd0;
      bank_wdata    = key;
      last_d        = key;
      rounds_done_d = 4'd1;
      round_cnt_d   = 4'd1;
      i_ready_d     = 1'b0;
      busy_d        = 1'b1;
      key_ready_d   = 1'b0;
    end else if (state_q == S_EXPAND) begin
      bank_we       = 1'b1;
      last_d        = next_key;
      rounds_done_d = round_cnt_q + 4'd1;
      if (round_cnt_q == NR_L) begin
        state_d     = S_READY;
        i_ready_d   = 1'b1;
        busy_d      = 1'b0;
        key_ready_d = 1'b1;
      end else begin
        round_cnt_d = round_cnt_q + 4'd1;
      end
    end
  end

  // Reads see the pre-edge rounds_done; a coincident load invalidates the schedule.
  always_comb begin
    rd_ok      = rk_req && !load && (rk_idx < rounds_done_q) && (rk_idx <= NR_L);
    rd_sel     = rd_ok ? rk_idx : 4'd0;
    rk_valid_d = rk_req;
    rk_err_d   = rk_req && !rd_ok;
    rk_data_d  = rd_ok ? bank_q[rd_sel] : 128'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rounds_done_q <= 4'd0;
      round_cnt_q   <= 4'd0;
      i_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
      key_ready_q   <= 1'b0;
      rk_valid_q    <= 1'b0;
      rk_err_q      <= 1'b0;
      rk_data_q     <= 128'h0;
      last_q        <= 128'h0;
    end else begin
      state_q       <= state_d;
      rounds_done_q <= rounds_done_d;
      round_cnt_q   <= round_cnt_d;
      i_ready_q     <= i_ready_d;
      busy_q        <= busy_d;
      key_ready_q   <= key_ready_d;
      rk_valid_q    <= rk_valid_d;
      rk_err_q      <= rk_err_d;
      rk_data_q     <= rk_data_d;
      last_q        <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bank_we) begin
      bank_q[bank_waddr] <= bank_wdata;
    end
  end

  assign i_ready   = i_ready_q;
  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_err    = rk_err_q;
  assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - randomized self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] key;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_err;
  logic [127:0] rk_data;
  logic         busy;
  logic         key_ready;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .key       (key),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_err    (rk_err),
    .rk_data   (rk_data),
    .busy      (busy),
    .key_ready (key_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: S-box derived from GF(2^8) inversion plus the affine map,
  // schedule from the word-recurrence form of the key expansion.
  logic [7:0]   sbox_m [256];
  logic [127:0] sched [11];
  bit           have_key;
  int           since;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox_m[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock: predict from pre-edge state and inputs, step, then compare.
  task automatic cycle();
    bit           expanding, accept, exp_err;
    int           avail;
    logic [127:0] exp_data;
    expanding = have_key && (since < 10);
    avail     = !have_key ? 0 : ((since + 1 > 11) ? 11 : since + 1);
    accept    = i_valid && !expanding;
    exp_err   = rk_req && (accept || int'(rk_idx) >= avail);
    exp_data  = 128'h0;
    if (rk_req && !exp_err) exp_data = sched[rk_idx];
    @(posedge clk);
    #1;
    if (accept) begin
      expand_model(key);
      have_key = 1'b1;
      since    = 0;
    end else if (have_key && since < 10) begin
      since++;
    end
    check("rk_valid",  128'(rk_valid),  128'(rk_req));
    check("rk_err",    128'(rk_err),    128'(exp_err));
    check("rk_data",   rk_data,         exp_data);
    check("i_ready",   128'(i_ready),   128'(!(have_key && since < 10)));
    check("busy",      128'(busy),      128'(have_key && since < 10));
    check("key_ready", 128'(key_ready), 128'(have_key && since >= 10));
  endtask

  task automatic check_reset_outputs();
    check("rst_i_ready",   128'(i_ready),   128'd1);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_key_ready", 128'(key_ready), 128'd0);
    check("rst_rk_valid",  128'(rk_valid),  128'd0);
    check("rst_rk_err",    128'(rk_err),    128'd0);
    check("rst_rk_data",   rk_data,         128'h0);
  endtask

  // Called #1 after an edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    have_key = 1'b0;
    since    = 0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
  endtask

  task automatic read_lit(input logic [3:0] idx, input logic [127:0] exp_d, input logic exp_e, input string tag);
    rk_req = 1'b1;
    rk_idx = idx;
    cycle();
    check({tag, "_data"}, rk_data, exp_d);
    check({tag, "_err"},  128'(rk_err), 128'(exp_e));
    rk_req = 1'b0;
  endtask

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    reset    = 1'b1;
    i_valid  = 1'b0;
    key      = 128'h0;
    rk_req   = 1'b0;
    rk_idx   = 4'd0;
    have_key = 1'b0;
    since    = 0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    read_lit(4'd0, 128'h0, 1'b1, "idle_idx0");

    key = KEY_A; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (2) cycle();
    read_lit(4'd2, A_RK2, 1'b0, "early_idx2");
    read_lit(4'd9, 128'h0, 1'b1, "early_idx9");
    repeat (8) cycle();
    read_lit(4'd1,  A_RK1,  1'b0, "a_idx1");
    read_lit(4'd10, A_RK10, 1'b0, "a_idx10");
    read_lit(4'd0,  KEY_A,  1'b0, "a_idx0");
    read_lit(4'd11, 128'h0, 1'b1, "a_idx11");
    read_lit(4'd15, 128'h0, 1'b1, "a_idx15");

    key = KEY_B; i_valid = 1'b1;
    repeat (10) cycle();
    i_valid = 1'b0;
    cycle();
    read_lit(4'd10, B_RK10, 1'b0, "b_idx10");

    key = {$urandom, $urandom, $urandom, $urandom};
    i_valid = 1'b1;
    repeat (14) cycle();
    i_valid = 1'b0;
    repeat (12) cycle();

    key = KEY_A; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (5) cycle();
    do_reset();
    read_lit(4'd0, 128'h0, 1'b1, "post_rst_idx0");
    key = KEY_B; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (11) cycle();
    read_lit(4'd10, B_RK10, 1'b0, "reload_idx10");

    for (int n = 0; n < 1500; n++) begin
      i_valid = ($urandom_range(0, 15) == 0);
      key     = {$urandom, $urandom, $urandom, $urandom};
      rk_req  = $urandom_range(0, 1) == 1;
      rk_idx  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
